// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states
// and the request legality check applied at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE,
        RESP
    } state_t;

    // Unsigned widths exist only for loads; any other funct3 is illegal.
    function automatic logic req_bad(input logic write, input logic [2:0] f3,
                                     input logic [1:0] off);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = write;
            F3_HU:   bad = write | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response channel and word-memory bus used by the LSU.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(parameter int unsigned ADDR_W = 6);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );
    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte/halfword lane handling: load extract+extend and store merge into a word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'h0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [31:0] res;
        res = old;
        case (f3)
            F3_B: begin
                case (off)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    default: res[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (off[1]) res[31:16] = wdata[15:0];
                else        res[15:0]  = wdata[15:0];
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    assign o_load   = load_ext(i_word, i_off, i_funct3);
    assign o_merged = store_merge(i_word, i_wdata, i_off, i_funct3);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time and drives a word-only
// data memory, adding byte/halfword loads and read-modify-write sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    state_t            r_state;
    state_t            w_next;
    logic              r_err;
    logic [2:0]        r_funct3;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;

    logic              w_accept;
    logic              w_bad;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    assign w_accept = req.req_valid && (r_state == IDLE);
    assign w_bad    = req_bad(req.req_write, req.req_funct3, req.req_addr[1:0]);

    lsu_lane u_lane (
        .i_word   (mem.mem_rdata),
        .i_wdata  (r_wdata),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_load   (w_load_data),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_bad)                          w_next = RESP;
                    else if (!req.req_write)            w_next = LOAD;
                    else if (req.req_funct3 == F3_W)    w_next = STORE;
                    else                                w_next = RMW_RD;
                end
            end
            LOAD:    w_next = RESP;
            RMW_RD:  w_next = STORE;
            STORE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req.req_ready  = (r_state == IDLE);
        req.resp_valid = (r_state == RESP);
        req.resp_err   = (r_state == RESP) && r_err;
        req.resp_rdata = r_rdata;
        mem.mem_read   = (r_state == LOAD) || (r_state == RMW_RD);
        mem.mem_write  = (r_state == STORE);
        mem.mem_wdata  = r_wdata;
        mem.mem_addr   = '0;
        if (r_state == LOAD || r_state == RMW_RD || r_state == STORE)
            mem.mem_addr = r_addr[ADDR_W+1:2];
    end

    // r_wdata carries raw store data until RMW_RD replaces it with the merged word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err    <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_err    <= w_bad;
                        r_funct3 <= req.req_funct3;
                        r_addr   <= req.req_addr[ADDR_W+1:0];
                        r_wdata  <= req.req_wdata;
                        if (w_bad) r_rdata <= '0;
                    end
                end
                LOAD:    r_rdata <= w_load_data;
                RMW_RD:  r_wdata <= w_merged;
                STORE:   r_rdata <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 64-word memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lsu_req_if rq();
    lsu_mem_if #(.ADDR_W(6)) mm();

    load_store_unit #(.ADDR_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (rq),
        .mem   (mm)
    );

    logic [31:0] mem [64];
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;

    assign mm.mem_rdata = mm.mem_read ? mem[mm.mem_addr] : 32'h0;

    always @(posedge clk) begin
        if (mm.mem_write) begin
            mem[mm.mem_addr] <= mm.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mm.mem_read) rd_cnt <= rd_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] rd, output logic er);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rq.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        rq.req_valid  = 1'b1;
        rq.req_write  = w;
        rq.req_funct3 = f3;
        rq.req_addr   = a;
        rq.req_wdata  = d;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        lat = 1;
        while (!rq.resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rq.resp_rdata;
        er = rq.resp_err;
    endtask

    task automatic run(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_err);
        int          lat;
        logic [31:0] rd;
        logic        er;
        do_req(w, f3, a, d, lat, rd, er);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
    endtask

    int unsigned w0, r0;
    int pulses, cyc, low_cnt, bad_ready, bad_both;

    initial begin
        rq.req_valid  = 1'b0;
        rq.req_write  = 1'b0;
        rq.req_funct3 = 3'b000;
        rq.req_addr   = 32'h0;
        rq.req_wdata  = 32'h0;

        #3;
        check("rst_resp_valid", {31'h0, rq.resp_valid}, 32'h0);
        check("rst_resp_rdata", rq.resp_rdata, 32'h0);
        check("rst_resp_err",   {31'h0, rq.resp_err}, 32'h0);
        check("rst_mem_read",   {31'h0, mm.mem_read}, 32'h0);
        check("rst_mem_write",  {31'h0, mm.mem_write}, 32'h0);
        check("rst_mem_addr",   32'(mm.mem_addr), 32'h0);
        check("rst_mem_wdata",  mm.mem_wdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Preload and load extension
        run("sw_w3", 1'b1, F3_W, 32'h0C, 32'h80FF_7F01, 2, 32'h0, 1'b0);
        check("mem_w3", mem[3], 32'h80FF_7F01);
        run("lw_0c",  1'b0, F3_W,  32'h0C, 32'h0, 2, 32'h80FF_7F01, 1'b0);
        run("lb_0f",  1'b0, F3_B,  32'h0F, 32'h0, 2, 32'hFFFF_FF80, 1'b0);
        run("lbu_0e", 1'b0, F3_BU, 32'h0E, 32'h0, 2, 32'h0000_00FF, 1'b0);
        run("lhu_0e", 1'b0, F3_HU, 32'h0E, 32'h0, 2, 32'h0000_80FF, 1'b0);
        run("lh_0c",  1'b0, F3_H,  32'h0C, 32'h0, 2, 32'h0000_7F01, 1'b0);
        run("lh_0e",  1'b0, F3_H,  32'h0E, 32'h0, 2, 32'hFFFF_80FF, 1'b0);

        // Read-modify-write
        run("sw_w2", 1'b1, F3_W, 32'h08, 32'h1122_3344, 2, 32'h0, 1'b0);
        w0 = wr_cnt;
        run("sb_09", 1'b1, F3_B, 32'h09, 32'h0000_00AA, 3, 32'h0, 1'b0);
        check("sb_09_writes", 32'(wr_cnt - w0), 32'd1);
        check("mem_w2_sb", mem[2], 32'h1122_AA44);
        w0 = wr_cnt;
        run("sh_0a", 1'b1, F3_H, 32'h0A, 32'h0000_BEEF, 3, 32'h0, 1'b0);
        check("sh_0a_writes", 32'(wr_cnt - w0), 32'd1);
        check("mem_w2_sh", mem[2], 32'hBEEF_AA44);
        run("lw_08", 1'b0, F3_W, 32'h08, 32'h0, 2, 32'hBEEF_AA44, 1'b0);

        // Error path: no memory traffic, zero data
        w0 = wr_cnt;
        r0 = rd_cnt;
        run("err_lw_02",  1'b0, F3_W,   32'h02, 32'h0, 1, 32'h0, 1'b1);
        run("err_sh_05",  1'b1, F3_H,   32'h05, 32'h1234, 1, 32'h0, 1'b1);
        run("err_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1);
        run("err_sbu",    1'b1, F3_BU,  32'h10, 32'h0, 1, 32'h0, 1'b1);
        check("err_no_write", 32'(wr_cnt - w0), 32'd0);
        check("err_no_read",  32'(rd_cnt - r0), 32'd0);

        // Address wrap
        run("sw_w0",   1'b1, F3_W, 32'h00,  32'hCAFE_F00D, 2, 32'h0, 1'b0);
        run("lw_wrap", 1'b0, F3_W, 32'h100, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
        run("sw_wrap", 1'b1, F3_W, 32'h104, 32'h0BAD_BEEF, 2, 32'h0, 1'b0);
        check("mem_w1_wrap", mem[1], 32'h0BAD_BEEF);

        // Held req_valid: six back-to-back LWs
        r0 = rd_cnt;
        pulses = 0; cyc = 0; low_cnt = 0; bad_ready = 0; bad_both = 0;
        @(negedge clk);
        rq.req_valid  = 1'b1;
        rq.req_write  = 1'b0;
        rq.req_funct3 = F3_W;
        rq.req_addr   = 32'h100;
        while (pulses < 6 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rq.req_ready) low_cnt++;
            if (rq.req_ready && (mm.mem_read || mm.mem_write || rq.resp_valid)) bad_ready++;
            if (mm.mem_read && mm.mem_write) bad_both++;
            if (rq.resp_valid) begin
                pulses++;
                check("b2b_rdata", rq.resp_rdata, 32'hCAFE_F00D);
                if (pulses == 6) rq.req_valid = 1'b0;
            end
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rq.resp_valid) pulses++;
        end
        check("b2b_pulses",    32'(pulses), 32'd6);
        check("b2b_low_cnt",   32'(low_cnt), 32'd12);
        check("b2b_bad_ready", 32'(bad_ready), 32'd0);
        check("b2b_both",      32'(bad_both), 32'd0);
        check("b2b_reads",     32'(rd_cnt - r0), 32'd6);

        // Reset during RMW_RD
        w0 = wr_cnt;
        @(negedge clk);
        rq.req_valid  = 1'b1;
        rq.req_write  = 1'b1;
        rq.req_funct3 = F3_B;
        rq.req_addr   = 32'h14;
        rq.req_wdata  = 32'h55;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        check("rmw_rd_read", {31'h0, mm.mem_read}, 32'h1);
        reset = 1'b0;
        #1;
        check("midrst_resp_valid", {31'h0, rq.resp_valid}, 32'h0);
        check("midrst_resp_rdata", rq.resp_rdata, 32'h0);
        check("midrst_resp_err",   {31'h0, rq.resp_err}, 32'h0);
        check("midrst_mem_read",   {31'h0, mm.mem_read}, 32'h0);
        check("midrst_mem_write",  {31'h0, mm.mem_write}, 32'h0);
        check("midrst_mem_addr",   32'(mm.mem_addr), 32'h0);
        check("midrst_mem_wdata",  mm.mem_wdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_write", 32'(wr_cnt - w0), 32'd0);
        check("midrst_ready",    {31'h0, rq.req_ready}, 32'h1);
        check("midrst_no_resp",  {31'h0, rq.resp_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
